// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle controller: state enum,
// opcode/funct constants, ALU encodings, datapath select codes and per-state control.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11,
        S_JALEX  = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // pcen qualification: FETCH loads PC on mem_ready, BEQEX on zero
    typedef enum logic [1:0] {
        PCEN_NONE   = 2'b00,
        PCEN_ALWAYS = 2'b01,
        PCEN_READY  = 2'b10,
        PCEN_ZERO   = 2'b11
    } pcen_mode_t;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        pcen_mode_t pcen_mode;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.irwrite   = 1'b1;
                c.pcen_mode = PCEN_READY;
                c.alusrcb   = SRCB_FOUR;
                c.pcsrc     = PCSRC_ALU;
            end
            S_DECODE: c.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.regdst   = DST_RT;
                c.memtoreg = WB_MEM;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_RTEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                c.regwrite = 1'b1;
                c.regdst   = DST_RD;
                c.memtoreg = WB_ALU;
            end
            S_BEQEX: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_B;
                c.aluop     = ALUOP_SUB;
                c.pcen_mode = PCEN_ZERO;
                c.pcsrc     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
                c.regdst   = DST_RT;
                c.memtoreg = WB_ALU;
            end
            S_JEX: begin
                c.pcen_mode = PCEN_ALWAYS;
                c.pcsrc     = PCSRC_JUMP;
            end
            S_JALEX: begin
                c.regwrite  = 1'b1;
                c.regdst    = DST_LINK;
                c.memtoreg  = WB_PC4;
                c.pcen_mode = PCEN_ALWAYS;
                c.pcsrc     = PCSRC_JUMP;
            end
            S_HALT:  c = c;
            default: c = c;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// Combinational ALU control decoder: fixed add/sub, or funct-driven for R-type.
module aludec
    import mc_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    // Map ALU operation class and funct field to the ALU control code
    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    F_ADD:   o_alucontrol = ALU_ADD;
                    F_SUB:   o_alucontrol = ALU_SUB;
                    F_AND:   o_alucontrol = ALU_AND;
                    F_OR:    o_alucontrol = ALU_OR;
                    F_SLT:   o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style controller with memory-stall watchdog.
// Define JAL_EN to add the jump-and-link (op 000011) execute state.
module mc_controller
    import mc_pkg::*;
#(
    parameter int STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic       fault
);

    localparam int CW = ($clog2(STALL_LIMIT + 1) > 4) ? $clog2(STALL_LIMIT + 1) : 4;

    state_t          r_state;
    ctrl_t           r_ctrl;
    logic [2:0]      r_alucontrol;
    logic [CW-1:0]   r_wait;
    logic            r_illegal;
    logic            r_fault;

    state_t          w_next;
    state_t          w_state_d;
    logic            w_illegal;
    logic            w_stall;
    logic            w_timeout;
    ctrl_t           w_ctrl;
    logic [2:0]      w_alucontrol;

    // Next-state selection; the stall watchdog overrides everything
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
`ifdef JAL_EN
                    OP_JAL:       w_next = S_JALEX;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   w_next = S_RTWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RTWB, S_ADDIWB, S_BEQEX, S_JEX, S_JALEX: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    assign w_stall   = r_ctrl.mem_req & ~mem_ready;
    assign w_timeout = w_stall & (r_wait == CW'(STALL_LIMIT - 1));
    assign w_state_d = w_timeout ? S_HALT : w_next;
    assign w_ctrl    = state_ctrl(w_state_d);

    aludec u_aludec (
        .i_aluop      (w_ctrl.aluop),
        .i_funct      (funct),
        .o_alucontrol (w_alucontrol)
    );

    // State, control, wait counter and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_ctrl       <= state_ctrl(S_FETCH);
            r_alucontrol <= ALU_ADD;
            r_wait       <= '0;
            r_illegal    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_ctrl       <= w_ctrl;
            r_alucontrol <= w_alucontrol;
            r_wait       <= (w_stall && (w_state_d == r_state)) ? r_wait + CW'(1) : '0;
            r_illegal    <= w_illegal;
            r_fault      <= r_fault | w_timeout;
        end
    end

    // PC load qualification; FETCH and BEQEX depend on same-cycle inputs
    always_comb begin
        pcen = 1'b0;
        case (r_ctrl.pcen_mode)
            PCEN_NONE:   pcen = 1'b0;
            PCEN_ALWAYS: pcen = 1'b1;
            PCEN_READY:  pcen = mem_ready;
            PCEN_ZERO:   pcen = zero;
            default:     pcen = 1'b0;
        endcase
    end

    assign mem_req    = r_ctrl.mem_req;
    assign memwrite   = r_ctrl.memwrite;
    assign iord       = r_ctrl.iord;
    assign irwrite    = r_ctrl.irwrite & mem_ready;
    assign regwrite   = r_ctrl.regwrite;
    assign regdst     = r_ctrl.regdst;
    assign memtoreg   = r_ctrl.memtoreg;
    assign alusrca    = r_ctrl.alusrca;
    assign alusrcb    = r_ctrl.alusrcb;
    assign alucontrol = r_alucontrol;
    assign pcsrc      = r_ctrl.pcsrc;
    assign illegal    = r_illegal;
    assign fault      = r_fault;

endmodule
